// File: rtl/pipe_pal_operand_packer.sv
// Packs a serial valid/ready word stream into (c, d) operand pairs for pipe_pal.
// An odd-length burst is padded with d = 0. Emitted pairs are counted.
module pipe_pal_operand_packer #(
  parameter int W_DATA = 32,
  parameter int W_CNT  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [W_DATA-1:0] i_data,
  input  logic              i_last,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [W_DATA-1:0] o_c,
  output logic [W_DATA-1:0] o_d,
  output logic              o_odd,
  output logic              o_last,
  output logic [W_CNT-1:0]  o_pair_cnt
);

  typedef enum logic {S_EMPTY, S_HALF} state_t;

  state_t            state_q;
  logic [W_DATA-1:0] cHold_q;
  logic              valid_q;
  logic [W_DATA-1:0] c_q;
  logic [W_DATA-1:0] d_q;
  logic              odd_q;
  logic              last_q;
  logic [W_CNT-1:0]  pairCnt_q;

  logic              outFree;
  logic              inXfer;
  logic              outXfer;
  logic              loadPair;
  logic [W_DATA-1:0] pairC_d;
  logic [W_DATA-1:0] pairD_d;
  logic              pairOdd_d;

  // Ready is derived only from the output register and reset, never from i_valid.
  assign outFree  = !valid_q || i_ready;
  assign o_ready  = outFree && !i_reset;
  assign inXfer   = i_valid && o_ready;
  assign outXfer  = valid_q && i_ready;
  assign loadPair = inXfer && ((state_q == S_HALF) || i_last);

  always_comb begin
    pairC_d   = i_data;
    pairD_d   = '0;
    pairOdd_d = 1'b1;
    if (state_q == S_HALF) begin
      pairC_d   = cHold_q;
      pairD_d   = i_data;
      pairOdd_d = 1'b0;
    end
  end

  // A new pair may replace the one being accepted downstream in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_EMPTY;
      cHold_q   <= '0;
      valid_q   <= 1'b0;
      c_q       <= '0;
      d_q       <= '0;
      odd_q     <= 1'b0;
      last_q    <= 1'b0;
      pairCnt_q <= '0;
    end else begin
      if (outXfer) begin
        pairCnt_q <= pairCnt_q + W_CNT'(1);
      end
      if (loadPair) begin
        valid_q <= 1'b1;
        c_q     <= pairC_d;
        d_q     <= pairD_d;
        odd_q   <= pairOdd_d;
        last_q  <= i_last;
      end else if (outXfer) begin
        valid_q <= 1'b0;
      end
      if (state_q == S_EMPTY) begin
        if (inXfer && !i_last) begin
          cHold_q <= i_data;
          state_q <= S_HALF;
        end
      end else if (inXfer) begin
        state_q <= S_EMPTY;
      end
    end
  end

  assign o_valid    = valid_q;
  assign o_c        = c_q;
  assign o_d        = d_q;
  assign o_odd      = odd_q;
  assign o_last     = last_q;
  assign o_pair_cnt = pairCnt_q;

endmodule

// File: tb/tb_pipe_pal_operand_packer.sv
// Bench for pipe_pal_operand_packer: directed vector table, corner sequences and a
// pair scoreboard; a second instance with a 2-bit counter checks wraparound.
module tb_pipe_pal_operand_packer;

  logic        clk;
  logic        i_reset;
  logic        i_valid;
  logic [31:0] i_data;
  logic        i_last;
  logic        i_ready;
  logic        o_ready;
  logic        o_valid;
  logic [31:0] o_c;
  logic [31:0] o_d;
  logic        o_odd;
  logic        o_last;
  logic [15:0] o_pair_cnt;

  logic        u2Ready;
  logic        u2Valid;
  logic [31:0] u2C;
  logic [31:0] u2D;
  logic        u2Odd;
  logic        u2Last;
  logic [1:0]  u2Cnt;

  pipe_pal_operand_packer #(.W_DATA(32), .W_CNT(16)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_last(i_last), .o_valid(o_valid), .i_ready(i_ready),
    .o_c(o_c), .o_d(o_d), .o_odd(o_odd), .o_last(o_last), .o_pair_cnt(o_pair_cnt)
  );

  pipe_pal_operand_packer #(.W_DATA(32), .W_CNT(2)) dutCnt2 (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(u2Ready),
    .i_data(i_data), .i_last(i_last), .o_valid(u2Valid), .i_ready(i_ready),
    .o_c(u2C), .o_d(u2D), .o_odd(u2Odd), .o_last(u2Last), .o_pair_cnt(u2Cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] c;
    logic [31:0] d;
    logic        odd;
    logic        last;
  } pair_t;

  typedef struct {
    logic        rst;
    logic        v;
    logic [31:0] d;
    logic        l;
    logic        r;
    logic        eV;
    logic [31:0] eC;
    logic [31:0] eD;
    logic        eOdd;
    logic        eLast;
    int          eCnt;
  } vec_t;

  pair_t       sbQ[$];
  logic        holding;
  logic [31:0] holdWord;
  int          modelCnt;
  logic        lastOutXfer;
  int          nChecks = 0;
  int          nFails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Post-edge scoreboard: o_valid must track whether an unaccepted pair exists.
  task automatic checkOutput();
    pair_t exp;
    check("o_valid", {31'b0, o_valid}, {31'b0, sbQ.size() != 0});
    if (sbQ.size() != 0) begin
      exp = sbQ[0];
      check("sb_c", o_c, exp.c);
      check("sb_d", o_d, exp.d);
      check("sb_odd", {31'b0, o_odd}, {31'b0, exp.odd});
      check("sb_last", {31'b0, o_last}, {31'b0, exp.last});
    end
    check("pair_cnt", {16'b0, o_pair_cnt}, 32'(modelCnt & 32'hFFFF));
    check("pair_cnt_w2", {30'b0, u2Cnt}, 32'(modelCnt & 3));
  endtask

  // Drive one cycle, judge the handshakes before the edge, then check after it.
  task automatic applyStimulus(input logic rst, input logic v, input logic [31:0] d,
                               input logic l, input logic r);
    logic inX;
    logic outX;
    logic expReady;
    i_reset = rst;
    i_valid = v;
    i_data  = d;
    i_last  = l;
    i_ready = r;
    #1;
    expReady = (!o_valid || r) && !rst;
    check("o_ready", {31'b0, o_ready}, {31'b0, expReady});
    inX  = v && expReady;
    outX = o_valid && r && !rst;
    if (rst) begin
      sbQ.delete();
      holding  = 1'b0;
      modelCnt = 0;
    end else begin
      if (outX) begin
        if (sbQ.size() != 0) void'(sbQ.pop_front());
        modelCnt++;
      end
      if (inX) begin
        if (holding) begin
          sbQ.push_back('{holdWord, d, 1'b0, l});
          holding = 1'b0;
        end else if (l) begin
          sbQ.push_back('{d, 32'h0, 1'b1, 1'b1});
        end else begin
          holdWord = d;
          holding  = 1'b1;
        end
      end
    end
    lastOutXfer = outX;
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  vec_t vecs[12];
  int   cntExp[5];
  int   cntIdx;

  initial begin
    holding  = 1'b0;
    holdWord = '0;
    modelCnt = 0;
    i_reset = 1'b1; i_valid = 1'b0; i_data = '0; i_last = 1'b0; i_ready = 1'b0;

    // rst v data l r | valid c d odd last cnt  (values seen after the edge)
    vecs[0]  = '{1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h00, 32'h00, 1'b0, 1'b0, 0};
    vecs[1]  = '{1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 1'b0, 32'h00, 32'h00, 1'b0, 1'b0, 0};
    vecs[2]  = '{1'b0, 1'b1, 32'h22, 1'b0, 1'b1, 1'b1, 32'h11, 32'h22, 1'b0, 1'b0, 0};
    vecs[3]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h11, 32'h22, 1'b0, 1'b0, 1};
    vecs[4]  = '{1'b0, 1'b1, 32'h33, 1'b1, 1'b1, 1'b1, 32'h33, 32'h00, 1'b1, 1'b1, 1};
    vecs[5]  = '{1'b0, 1'b1, 32'h44, 1'b0, 1'b1, 1'b0, 32'h33, 32'h00, 1'b1, 1'b1, 2};
    vecs[6]  = '{1'b0, 1'b1, 32'h55, 1'b1, 1'b1, 1'b1, 32'h44, 32'h55, 1'b0, 1'b1, 2};
    vecs[7]  = '{1'b0, 1'b1, 32'h66, 1'b0, 1'b1, 1'b0, 32'h44, 32'h55, 1'b0, 1'b1, 3};
    vecs[8]  = '{1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h00, 32'h00, 1'b0, 1'b0, 0};
    vecs[9]  = '{1'b0, 1'b1, 32'h77, 1'b0, 1'b1, 1'b0, 32'h00, 32'h00, 1'b0, 1'b0, 0};
    vecs[10] = '{1'b0, 1'b1, 32'h88, 1'b0, 1'b1, 1'b1, 32'h77, 32'h88, 1'b0, 1'b0, 0};
    vecs[11] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h77, 32'h88, 1'b0, 1'b0, 1};

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].r);
      check($sformatf("vec%0d_valid", i), {31'b0, o_valid}, {31'b0, vecs[i].eV});
      check($sformatf("vec%0d_c", i), o_c, vecs[i].eC);
      check($sformatf("vec%0d_d", i), o_d, vecs[i].eD);
      check($sformatf("vec%0d_odd", i), {31'b0, o_odd}, {31'b0, vecs[i].eOdd});
      check($sformatf("vec%0d_last", i), {31'b0, o_last}, {31'b0, vecs[i].eLast});
      check($sformatf("vec%0d_cnt", i), {16'b0, o_pair_cnt}, 32'(vecs[i].eCnt));
    end

    // Stalled pair holds for five cycles and blocks input; then two more pairs flow.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'hA, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'hB, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 32'hC, 1'b0, 1'b0);
      check("stall_ready", {31'b0, o_ready}, 32'h0);
      check("stall_c", o_c, 32'hA);
      check("stall_d", o_d, 32'hB);
    end
    applyStimulus(1'b0, 1'b1, 32'hC, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'hD, 1'b0, 1'b1);
    check("resume_c", o_c, 32'hC);
    check("resume_d", o_d, 32'hD);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("resume_cnt", {16'b0, o_pair_cnt}, 32'd2);

    // Two single-word bursts back to back: accept and reload in one cycle.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h91, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h92, 1'b1, 1'b1);
    check("nobubble_valid", {31'b0, o_valid}, 32'h1);
    check("nobubble_c", o_c, 32'h92);
    check("nobubble_cnt", {16'b0, o_pair_cnt}, 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("nobubble_cnt2", {16'b0, o_pair_cnt}, 32'd2);

    // Ten-word stream into the 2-bit counter instance.
    cntExp = '{1, 2, 3, 0, 1};
    cntIdx = 0;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, i < 10, 32'(i + 1), 1'b0, 1'b1);
      if (lastOutXfer) begin
        if (cntIdx < 5) check("wrap_seq", {30'b0, u2Cnt}, 32'(cntExp[cntIdx]));
        cntIdx++;
      end
    end
    check("wrap_pairs", 32'(cntIdx), 32'd5);

    // Random traffic with occasional reset, checked by the scoreboard only.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, $urandom,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
